// File: rtl/mean_ctrl_pkg.sv
// rtl/mean_ctrl_pkg.sv - state encoding and default sizing for the running-mean controller
package mean_ctrl_pkg;

   localparam int STATE_W           = 3;
   localparam int DEFAULT_N_SAMPLES = 16;

   localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] S_CLR      = 3'd1;
   localparam logic [STATE_W-1:0] S_ACC      = 3'd2;
   localparam logic [STATE_W-1:0] S_DIV      = 3'd3;
   localparam logic [STATE_W-1:0] S_LOAD     = 3'd4;
   localparam logic [STATE_W-1:0] S_DONE     = 3'd5;
   localparam logic [STATE_W-1:0] S_WAIT_REL = 3'd6;

endpackage

// File: rtl/mean_controller.sv
// rtl/mean_controller.sv - sequencing FSM for the 8-bit running-mean datapath
// Optional in-flight cancel via abort is built only when MEAN_CTRL_ABORT_EN is defined.
module mean_controller
   import mean_ctrl_pkg::*;
#(
   parameter int  N_SAMPLES = DEFAULT_N_SAMPLES,
   localparam int CNT_W     = $clog2(N_SAMPLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             data_valid,
   input  logic             abort,
   output logic             ready,
   output logic             done,
   output logic             acc_clr,
   output logic             acc_en,
   output logic             shift_en,
   output logic             ld_mean,
   output logic [CNT_W-1:0] sample_cnt
);

   generate
      if (N_SAMPLES < 2 || N_SAMPLES > 256 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
         $error("mean_controller: N_SAMPLES must be a power of two in 2..256");
      end
   endgenerate

   logic [STATE_W-1:0] state;
   logic [CNT_W-1:0]   shift_cnt;
   logic               abort_clr;
   logic               abort_hit;

`ifdef MEAN_CTRL_ABORT_EN
   assign abort_hit = abort && (state == S_CLR || state == S_ACC ||
                                state == S_DIV || state == S_LOAD);
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         sample_cnt <= '0;
         shift_cnt  <= '0;
         abort_clr  <= 1'b0;
      end else begin
         abort_clr <= 1'b0;
         if (abort_hit) begin
            // Cancelled run clears the datapath during the first idle cycle
            state      <= S_IDLE;
            sample_cnt <= '0;
            abort_clr  <= 1'b1;
         end else begin
            case (state)
               S_IDLE: if (start) state <= S_CLR;
               S_CLR: begin
                  sample_cnt <= '0;
                  state      <= S_ACC;
               end
               S_ACC: if (data_valid) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  if (sample_cnt == CNT_W'(N_SAMPLES - 1)) begin
                     state     <= S_DIV;
                     shift_cnt <= CNT_W'(CNT_W - 1);
                  end
               end
               S_DIV: begin
                  if (shift_cnt == '0) state <= S_LOAD;
                  else shift_cnt <= shift_cnt - 1'b1;
               end
               S_LOAD:     state <= S_DONE;
               S_DONE:     state <= start ? S_WAIT_REL : S_IDLE;
               S_WAIT_REL: if (!start) state <= S_IDLE;
               default:    state <= S_IDLE;
            endcase
         end
      end
   end

   assign ready    = (state == S_IDLE);
   assign done     = (state == S_DONE);
   assign acc_clr  = (state == S_CLR) || abort_clr;
   assign acc_en   = (state == S_ACC) && data_valid;
   assign shift_en = (state == S_DIV);
   assign ld_mean  = (state == S_LOAD);

endmodule

// File: tb/tb_mean_controller.sv
// tb/tb_mean_controller.sv - scoreboard bench with behavioural accumulator/shifter datapath
// Abort expectations follow MEAN_CTRL_ABORT_EN as seen by the bench build.
module tb_mean_controller;

   localparam int N  = 16;
   localparam int CW = $clog2(N);

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, data_valid = 1'b0, abort = 1'b0;
   logic ready, done, acc_clr, acc_en, shift_en, ld_mean;
   logic [CW-1:0] sample_cnt;
   logic [7:0]    din = 8'd0;
   logic [7+CW:0] acc_m = '0;
   logic [7:0]    mean_m = 8'd0;
   logic [7:0]    exp_q[$];
   int errors = 0, checks = 0;
   int n_acc_en = 0, n_done = 0, n_ld = 0;

   always #5 clk = ~clk;

   mean_controller #(.N_SAMPLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .data_valid(data_valid), .abort(abort),
      .ready(ready), .done(done), .acc_clr(acc_clr), .acc_en(acc_en),
      .shift_en(shift_en), .ld_mean(ld_mean), .sample_cnt(sample_cnt)
   );

   always @(posedge clk) begin
      if (acc_clr) acc_m <= '0;
      else if (acc_en) acc_m <= acc_m + {{CW{1'b0}}, din};
      else if (shift_en) acc_m <= acc_m >> 1;
      if (ld_mean) mean_m <= acc_m[7:0];
      if (acc_en) n_acc_en <= n_acc_en + 1;
      if (done) n_done <= n_done + 1;
      if (ld_mean) n_ld <= n_ld + 1;
   end

   task automatic start_run(input logic [7:0] e, input bit hold);
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      checks++;
      if (acc_clr !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL accept: acc_clr=%b ready=%b required 1 0", acc_clr, ready);
      end
   endtask

   task automatic wait_done(input int c0, input bit gap, input bit busy, output int lat);
      int cyc = c0;
      int k = 0;
      bit seen = 0;
      logic [7:0] e;
      lat = -1;
      while (!seen && cyc < c0 + 100) begin
         @(negedge clk);
         cyc++;
         if (busy) start = (cyc == 5 || cyc == 19);
         if (gap) begin
            data_valid = ~data_valid;
            din = 8'(k);
         end
         #1;
         if (gap && acc_en) k++;
         checks++;
         if ($countones({acc_clr, acc_en, shift_en, ld_mean, done}) > 1) begin
            errors++;
            $display("FAIL exclusive: cyc=%0d strobes=%b required at most one",
                     cyc, {acc_clr, acc_en, shift_en, ld_mean, done});
         end
         if (!gap && cyc == 10) begin
            checks++;
            if (sample_cnt !== CW'(9)) begin
               errors++;
               $display("FAIL sample_cnt_mid: got %0d required 9", sample_cnt);
            end
         end
         if (done) begin
            seen = 1;
            lat  = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard: done with no expected mean queued");
            end else begin
               e = exp_q.pop_front();
               if (mean_m !== e) begin
                  errors++;
                  $display("FAIL mean: got %0d required %0d", mean_m, e);
               end
            end
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within 100 cycles of cycle %0d", c0);
      end
   endtask

   task automatic check_lat(input string name, input int lat);
      checks++;
      if (lat != 2 + N + CW) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, 2 + N + CW);
      end
   endtask

   task automatic test_reset();
      int d0;
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ready, done, acc_clr, acc_en, shift_en, ld_mean} !== 6'b100000 || sample_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: outs=%b cnt=%0d required 100000 0",
                  {ready, done, acc_clr, acc_en, shift_en, ld_mean}, sample_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      data_valid = 1'b1;
      din = 8'd3;
      start_run(8'd3, 0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({ready, done, acc_clr, acc_en, shift_en, ld_mean} !== 6'b100000 || sample_cnt !== '0) begin
         errors++;
         $display("FAIL reset_mid_run: outs=%b cnt=%0d required 100000 0",
                  {ready, done, acc_clr, acc_en, shift_en, ld_mean}, sample_cnt);
      end
      exp_q.delete();
      d0 = n_done;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (n_done != d0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_done: done pulses=%0d ready=%b required 0 1", n_done - d0, ready);
      end
   endtask

   task automatic test_constant();
      int lat;
      data_valid = 1'b1;
      din = 8'd25;
      start_run(8'd25, 0);
      wait_done(0, 0, 0, lat);
      check_lat("constant", lat);
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_back: got %b required 1", ready);
      end
   endtask

   task automatic test_gaps();
      int lat, a0, d0;
      a0 = n_acc_en;
      d0 = n_done;
      data_valid = 1'b0;
      start_run(8'd7, 0);
      wait_done(0, 1, 0, lat);
      data_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (n_acc_en - a0 != N || n_done - d0 != 1) begin
         errors++;
         $display("FAIL gaps: acc_en=%0d done=%0d required %0d 1", n_acc_en - a0, n_done - d0, N);
      end
   endtask

   task automatic test_hold_start();
      int lat, l0;
      data_valid = 1'b1;
      din = 8'd200;
      start_run(8'd200, 1);
      wait_done(0, 0, 0, lat);
      check_lat("hold", lat);
      l0 = n_ld;
      repeat (4) @(negedge clk);
      checks++;
      if (ready !== 1'b0 || acc_clr !== 1'b0 || n_ld != l0) begin
         errors++;
         $display("FAIL wait_rel: ready=%b acc_clr=%b loads=%0d required 0 0 0", ready, acc_clr, n_ld - l0);
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL release: ready=%b required 1", ready);
      end
      din = 8'd90;
      start_run(8'd90, 0);
      wait_done(0, 0, 0, lat);
      check_lat("rerun", lat);
      @(negedge clk);
   endtask

   task automatic test_busy_start();
      int lat, d0;
      d0 = n_done;
      data_valid = 1'b1;
      din = 8'd255;
      start_run(8'd255, 0);
      wait_done(0, 0, 1, lat);
      check_lat("busy", lat);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (n_done - d0 != 1 || ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignored: done=%0d ready=%b required 1 1", n_done - d0, ready);
      end
   endtask

   task automatic test_abort();
      int lat;
      data_valid = 1'b1;
      din = 8'd40;
      start_run(8'd40, 0);
      repeat (6) @(negedge clk);
      checks++;
      if (sample_cnt !== CW'(5)) begin
         errors++;
         $display("FAIL abort_point: sample_cnt=%0d required 5", sample_cnt);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
`ifdef MEAN_CTRL_ABORT_EN
      begin
         int d0, l0;
         checks++;
         if (ready !== 1'b1 || acc_clr !== 1'b1 || sample_cnt !== '0) begin
            errors++;
            $display("FAIL abort_idle: ready=%b acc_clr=%b cnt=%0d required 1 1 0", ready, acc_clr, sample_cnt);
         end
         exp_q.delete();
         d0 = n_done;
         l0 = n_ld;
         repeat (30) @(negedge clk);
         checks++;
         if (n_done != d0 || n_ld != l0) begin
            errors++;
            $display("FAIL abort_quiet: done=%0d ld_mean=%0d required 0 0", n_done - d0, n_ld - l0);
         end
         din = 8'd17;
         start_run(8'd17, 0);
         wait_done(0, 0, 0, lat);
         check_lat("post_abort", lat);
      end
`else
      wait_done(7, 0, 0, lat);
      check_lat("abort_ignored", lat);
`endif
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_constant();
      test_gaps();
      test_hold_start();
      test_busy_start();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
